// File: rtl/sdram_arbiter.sv
// Fixed-priority arbiter sharing one SDRAM command port between video fetch, Z80 CPU and
// loader DMA, with ROM write protection and a loader starvation guard.
module sdram_arbiter #(
  parameter int              AW     = 24,
  parameter logic [AW-1:0]   VBASE  = 24'h4000,
  parameter logic [15:0]     ROMTOP = 16'h4000,
  parameter int              STARVE = 4
) (
  input  logic          clock,
  input  logic          reset,
  // video fetch
  input  logic          vce,
  input  logic [12:0]   va,
  output logic [7:0]    vq,
  // Z80 bus
  input  logic          ce,
  input  logic          mreq,
  input  logic          rd,
  input  logic          wr,
  input  logic [15:0]   a,
  input  logic [7:0]    d,
  output logic [7:0]    q,
  // loader DMA
  input  logic          ldrReq,
  input  logic          ldrWe,
  input  logic [AW-1:0] ldrA,
  input  logic [7:0]    ldrD,
  output logic [7:0]    ldrQ,
  output logic          ldrAck,
  // SDRAM controller command port
  output logic          sdrReq,
  output logic          sdrWe,
  output logic [AW-1:0] sdrA,
  output logic [7:0]    sdrD,
  input  logic [7:0]    sdrQ,
  input  logic          sdrAck,
  // status
  output logic          vovr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;
  localparam logic [1:0] S_LDR  = 2'd3;

  localparam int             SW         = $clog2(STARVE + 1);
  localparam logic [SW-1:0]  STARVE_CNT = SW'(STARVE);

  logic [1:0]    state;
  logic          v_pend;
  logic [AW-1:0] v_addr;
  logic          c_pend;
  logic          c_rom;
  logic          c_armed;
  logic          c_we;
  logic [15:0]   c_addr;
  logic [7:0]    c_data;
  logic [SW-1:0] starve;

  // NOTE: all state uses non-blocking assignments; where one register is written twice in
  // this block (completion clear, then a fresh capture), the later assignment wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      vq      <= 8'h00;
      q       <= 8'h00;
      ldrQ    <= 8'h00;
      ldrAck  <= 1'b0;
      sdrReq  <= 1'b0;
      sdrWe   <= 1'b0;
      sdrA    <= '0;
      sdrD    <= 8'h00;
      vovr    <= 1'b0;
      v_pend  <= 1'b0;
      v_addr  <= '0;
      c_pend  <= 1'b0;
      c_rom   <= 1'b0;
      c_armed <= 1'b1;
      c_we    <= 1'b0;
      c_addr  <= 16'h0000;
      c_data  <= 8'h00;
      starve  <= '0;
    end else begin
      ldrAck <= 1'b0;

      // ROM-region writes live for a single clock and never reach SDRAM
      if (c_pend && c_rom) begin
        c_pend <= 1'b0;
        c_rom  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (v_pend) begin
            state  <= S_VID;
            sdrReq <= 1'b1;
            sdrWe  <= 1'b0;
            sdrA   <= v_addr;
          end else if (ldrReq && starve == STARVE_CNT) begin
            state  <= S_LDR;
            sdrReq <= 1'b1;
            sdrWe  <= ldrWe;
            sdrA   <= ldrA;
            sdrD   <= ldrD;
          end else if (c_pend && !c_rom) begin
            state  <= S_CPU;
            sdrReq <= 1'b1;
            sdrWe  <= c_we;
            sdrA   <= {{(AW-16){1'b0}}, c_addr};
            sdrD   <= c_data;
          end else if (ldrReq) begin
            state  <= S_LDR;
            sdrReq <= 1'b1;
            sdrWe  <= ldrWe;
            sdrA   <= ldrA;
            sdrD   <= ldrD;
          end
        end
        S_VID: begin
          if (sdrAck) begin
            vq     <= sdrQ;
            v_pend <= 1'b0;
            sdrReq <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_CPU: begin
          if (sdrAck) begin
            if (!sdrWe) q <= sdrQ;
            c_pend <= 1'b0;
            if (ldrReq && starve != STARVE_CNT) starve <= starve + SW'(1);
            sdrReq <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_LDR: begin
          if (sdrAck) begin
            if (!sdrWe) ldrQ <= sdrQ;
            ldrAck <= 1'b1;
            starve <= '0;
            sdrReq <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          sdrReq <= 1'b0;
          state  <= S_IDLE;
        end
      endcase

      if (vce) begin
        if (v_pend) vovr <= 1'b1;
        v_pend <= 1'b1;
        v_addr <= VBASE + {{(AW-13){1'b0}}, va};
      end

      // one capture per mreq cycle: the CPU holds mreq low across several ce samples
      if (ce) begin
        if (mreq) begin
          c_armed <= 1'b1;
        end else if (c_armed && (!rd || !wr)) begin
          c_armed <= 1'b0;
          c_pend  <= 1'b1;
          c_addr  <= a;
          c_data  <= d;
          c_we    <= !wr;
          c_rom   <= !wr && (a < ROMTOP);
        end
      end
    end
  end

endmodule
